bit_inverter: RTL and testbench

Controlled bit inverter. Each output bit is the data bit (in0) passed through unchanged when its control bit (in1) is 0, and inverted when its control bit is 1; functionally out = in0 XOR in1. It is a leaf datapath block for the logic/memory exercise set, with an optional output register so it can sit on a clocked pipeline path.

---
 rtl/bit_inverter.sv | 52 +++++
 tb/tb_bit_inverter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bit_inverter.sv
// Controlled bit inverter: each result bit is in0 inverted wherever in1 is set.
// Optional output register with a valid flag for use on clocked pipeline paths.
module bit_inverter #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_result;

    assign w_result = in0 ^ in1;

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] r_out;
            logic             r_valid;

            // Capture the result on qualified edges; hold data otherwise.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out   <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= en;
                    if (en) begin
                        r_out <= w_result;
                    end else begin
                        r_out <= r_out;
                    end
                end
            end

            assign out       = r_out;
            assign out_valid = r_valid;
        end else begin : g_comb
            // The clock has no role in the combinational variant.
            logic w_unused_clk;

            assign w_unused_clk = clk;
            assign out          = w_result;
            assign out_valid    = en & ~rst;
        end
    endgenerate

endmodule

// File: tb/tb_bit_inverter.sv
// Randomized self-checking bench for bit_inverter in registered (1- and 8-bit)
// and combinational configurations against a per-bit arithmetic reference.
module tb_bit_inverter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       a1, b1, ac, bc;
    logic [7:0] a8, b8;
    logic       o1, v1, oc, vc, v8;
    logic [7:0] o8;

    logic [7:0] m1, m8;
    logic       mv;
    int         n_cmp;
    int         n_err;

    bit_inverter #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
        .clk(clk), .rst(rst), .en(en), .in0(a1), .in1(b1), .out(o1), .out_valid(v1)
    );
    bit_inverter #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
        .clk(clk), .rst(rst), .en(en), .in0(a8), .in1(b8), .out(o8), .out_valid(v8)
    );
    bit_inverter #(.WIDTH(1), .REG_OUT(1'b0)) u_c1 (
        .clk(clk), .rst(rst), .en(en), .in0(ac), .in1(bc), .out(oc), .out_valid(vc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a bit flips exactly when data plus control is odd.
    function automatic logic [7:0] ref_inv(input logic [7:0] a, input logic [7:0] b, input int w);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 0; i < w; i++) begin
            r[i] = ((int'(a[i]) + int'(b[i])) % 2) == 1;
        end
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [7:0] ce;
        check_val("w1_out", {7'd0, o1}, m1);
        check_val("w1_valid", {7'd0, v1}, {7'd0, mv});
        check_val("w8_out", o8, m8);
        check_val("w8_valid", {7'd0, v8}, {7'd0, mv});
        ce = ref_inv({7'd0, ac}, {7'd0, bc}, 1);
        check_val("comb_out", {7'd0, oc}, ce);
        check_val("comb_valid", {7'd0, vc}, {7'd0, (en == 1'b1 && rst == 1'b0)});
    endtask

    // Advance one edge, update the reference the way the outputs should move, then check.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m1 = 8'd0;
            m8 = 8'd0;
            mv = 1'b0;
        end else begin
            mv = en;
            if (en) begin
                m1 = ref_inv({7'd0, a1}, {7'd0, b1}, 1);
                m8 = ref_inv(a8, b8, 8);
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        logic [1:0] pair;
        n_cmp = 0;
        n_err = 0;
        m1 = 8'd0;
        m8 = 8'd0;
        mv = 1'b0;
        rst = 1'b1;
        en = 1'b0;
        {a1, b1, ac, bc} = 4'd0;
        a8 = 8'd0;
        b8 = 8'd0;

        #2;
        check_all();
        tick();
        #3 rst = 1'b0;

        // Truth table on the 1-bit registered instance.
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pair = 2'(i);
            a1 = pair[0];
            b1 = pair[1];
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            tick();
        end
        tick();
        check_val("tt_last", {7'd0, o1}, 8'd0);

        // Hold with en low.
        a1 = 1'b1; b1 = 1'b0;
        tick();
        check_val("hold_cap", {7'd0, o1}, 8'd1);
        en = 1'b0; a1 = 1'b0; b1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("hold_out", {7'd0, o1}, 8'd1);
            check_val("hold_valid", {7'd0, v1}, 8'd0);
        end

        // Wide vector with fixed patterns.
        en = 1'b1; a8 = 8'hA5; b8 = 8'h0F;
        tick();
        check_val("wide_0F", o8, 8'hAA);
        b8 = 8'hFF;
        tick();
        check_val("wide_FF", o8, 8'h5A);
        b8 = 8'h00;
        tick();
        check_val("wide_00", o8, 8'hA5);

        // Asynchronous reset mid-cycle with out high.
        a1 = 1'b1; b1 = 1'b0;
        tick();
        #3 rst = 1'b1;
        #1;
        m1 = 8'd0; m8 = 8'd0; mv = 1'b0;
        check_all();
        check_val("async_rst", {7'd0, o1}, 8'd0);
        tick();
        #3 rst = 1'b0;

        // Combinational sweep without relying on clock edges.
        for (int i = 0; i < 4; i++) begin
            pair = 2'(i);
            ac = pair[0];
            bc = pair[1];
            #2;
            check_val("comb_tt", {7'd0, oc}, {7'd0, (pair == 2'd1 || pair == 2'd2)});
            check_val("comb_v", {7'd0, vc}, 8'd1);
        end
        en = 1'b0;
        #1 check_val("comb_v_en0", {7'd0, vc}, 8'd0);
        en = 1'b1;
        rst = 1'b1;
        #1 check_val("comb_v_rst", {7'd0, vc}, 8'd0);
        check_val("comb_out_rst", {7'd0, oc}, ref_inv({7'd0, ac}, {7'd0, bc}, 1));
        m1 = 8'd0; m8 = 8'd0; mv = 1'b0;
        tick();
        #3 rst = 1'b0;

        // Random traffic with occasional reset pulses.
        for (int n = 0; n < 300; n++) begin
            en = ($urandom_range(0, 3) != 0);
            a1 = 1'($urandom); b1 = 1'($urandom);
            ac = 1'($urandom); bc = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom);
            tick();
            if ($urandom_range(0, 19) == 0) begin
                #3 rst = 1'b1;
                #1;
                m1 = 8'd0; m8 = 8'd0; mv = 1'b0;
                check_all();
                tick();
                #3 rst = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
